// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline core / memory model and the unified-memory arbiter.
// The slave modport is the arbiter; the master modport is the environment around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_stall;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [1:0]        dm_wsize;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_stall;
  logic              dm_valid;
  logic              dm_err;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_wsize;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [15:0]       if_wait_cnt;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_wsize, dm_addr, dm_wdata, mem_rdata,
    output if_stall, if_valid, if_rdata, dm_stall, dm_valid, dm_err, dm_rdata,
           mem_en, mem_we, mem_wsize, mem_addr, mem_wdata, if_wait_cnt
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_wsize, dm_addr, dm_wdata, mem_rdata,
    input  if_stall, if_valid, if_rdata, dm_stall, dm_valid, dm_err, dm_rdata,
           mem_en, mem_we, mem_wsize, mem_addr, mem_wdata, if_wait_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the IF and DM pipeline stages: one access per cycle,
// DM priority with bounded IF starvation, DM alignment checking, one-cycle read latency.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_IF,
    RESP_DM,
    RESP_DM_ERR
  } resp_src_e;

  resp_src_e           resp_src, resp_src_nxt;
  logic                resp_dm_load;
  logic [STARVE_W-1:0] starve;
  logic [15:0]         wait_cnt;
  logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;

  logic starved;
  logic if_grant, dm_grant, dm_ok;
  logic dm_misaligned;
  logic if_stall, if_valid, dm_valid;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    dm_misaligned = 1'b0;
    case (bus.dm_wsize)
      2'b01:   dm_misaligned = bus.dm_addr[0];
      2'b10:   dm_misaligned = 1'b0;
      default: dm_misaligned = |bus.dm_addr[1:0];
    endcase
  end

  // DM wins contention until IF has been denied STARVE_MAX times in a row.
  assign starved  = (starve == STARVE_LIM);
  assign if_grant = ~rst & bus.if_req & (~bus.dm_req | starved);
  assign dm_grant = ~rst & bus.dm_req & ~if_grant;
  assign dm_ok    = dm_grant & ~dm_misaligned;

  assign if_stall = bus.if_req & ~if_grant;
  assign if_valid = ~rst & (resp_src == RESP_IF);
  assign dm_valid = ~rst & (resp_src == RESP_DM);

  always_comb begin
    bus.mem_en    = if_grant | dm_ok;
    bus.mem_we    = dm_ok & bus.dm_we;
    bus.mem_addr  = '0;
    bus.mem_wsize = 2'b00;
    bus.mem_wdata = '0;
    if (if_grant) begin
      bus.mem_addr = bus.if_addr;
    end else if (dm_ok) begin
      bus.mem_addr = bus.dm_addr;
    end
    if (bus.mem_we) begin
      bus.mem_wsize = bus.dm_wsize;
      bus.mem_wdata = bus.dm_wdata;
    end
  end

  always_comb begin
    resp_src_nxt = RESP_NONE;
    if (if_grant) begin
      resp_src_nxt = RESP_IF;
    end else if (dm_grant) begin
      resp_src_nxt = dm_misaligned ? RESP_DM_ERR : RESP_DM;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: every register here is cleared by reset; there is no storage array in
    // this block that could be left unreset.
    if (rst) begin
      resp_src     <= RESP_NONE;
      resp_dm_load <= 1'b0;
      starve       <= '0;
      wait_cnt     <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      resp_src     <= resp_src_nxt;
      resp_dm_load <= dm_ok & ~bus.dm_we;

      if (bus.if_req && dm_grant) begin
        starve <= starved ? starve : starve + 1'b1;
      end else begin
        starve <= '0;
      end

      if (if_stall && wait_cnt != 16'hFFFF) begin
        wait_cnt <= wait_cnt + 16'd1;
      end

      if (resp_src == RESP_IF) begin
        if_rdata_q <= bus.mem_rdata;
      end
      if (resp_src == RESP_DM && resp_dm_load) begin
        dm_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Read data is forwarded straight from memory in the response cycle, then held.
  assign bus.if_stall    = if_stall;
  assign bus.dm_stall    = bus.dm_req & ~dm_grant;
  assign bus.if_valid    = if_valid;
  assign bus.dm_valid    = dm_valid;
  assign bus.dm_err      = ~rst & (resp_src == RESP_DM_ERR);
  assign bus.if_rdata    = if_valid ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata    = (dm_valid && resp_dm_load) ? bus.mem_rdata : dm_rdata_q;
  assign bus.if_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte-addressed memory model, response scoreboard
// checked every cycle, and per-cycle checks of grants, stalls and the wait counter.
module tb_mem_port_arbiter;

  typedef enum logic [2:0] {G_NONE, G_IF, G_DM, G_DMS, G_ERR} grant_e;
  typedef enum logic [1:0] {K_IF, K_DM_LD, K_DM_ST, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks;
  int          n_errors;
  resp_t       sb[$];
  logic [31:0] last_if;
  logic [31:0] last_dm;
  logic [15:0] exp_wait;
  logic        prev_stall;
  logic        prev_rst;
  logic [7:0]  mem [1024];
  int          mem_a;
  int          mem_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + i] <= w[8*i +: 8];
  endtask

  // Synchronous memory: writes land at the edge, reads are valid the following cycle.
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      mem_a = int'(bus.mem_addr);
      if (bus.mem_we) begin
        case (bus.mem_wsize)
          2'b01:   mem_n = 2;
          2'b10:   mem_n = 1;
          default: mem_n = 4;
        endcase
        for (int i = 0; i < mem_n; i++) mem[(mem_a + i) & 1023] <= bus.mem_wdata[8*i +: 8];
      end else begin
        mem_a = mem_a & ~3;
        bus.mem_rdata <= {mem[mem_a + 3], mem[mem_a + 2], mem[mem_a + 1], mem[mem_a]};
      end
    end
  end

  // Scoreboard: each entry is due exactly one negedge after the cycle it was pushed in.
  always @(negedge clk) begin
    logic [2:0] pulses;
    resp_t      r;
    pulses = {bus.if_valid, bus.dm_valid, bus.dm_err};
    if (sb.size() == 0) begin
      check("idle_pulses", {29'd0, pulses}, 32'd0);
    end else begin
      r = sb.pop_front();
      case (r.kind)
        K_IF: begin
          check("if_resp_pulses", {29'd0, pulses}, 32'd4);
          check("if_rdata", bus.if_rdata, r.data);
          check("dm_rdata_hold", bus.dm_rdata, last_dm);
          last_if = r.data;
        end
        K_DM_LD: begin
          check("dm_load_pulses", {29'd0, pulses}, 32'd2);
          check("dm_rdata", bus.dm_rdata, r.data);
          check("if_rdata_hold", bus.if_rdata, last_if);
          last_dm = r.data;
        end
        K_DM_ST: begin
          check("dm_store_pulses", {29'd0, pulses}, 32'd2);
          check("dm_rdata_hold_st", bus.dm_rdata, last_dm);
        end
        default: begin
          check("dm_err_pulses", {29'd0, pulses}, 32'd1);
          check("dm_rdata_hold_err", bus.dm_rdata, last_dm);
        end
      endcase
    end
  end

  // One clock cycle: drive inputs, check the combinational grant outputs, queue the response.
  task automatic step(input logic r, input logic ir, input logic [9:0] ia,
                      input logic dr, input logic dwe, input logic [1:0] dsz,
                      input logic [9:0] da, input logic [31:0] dwd,
                      input grant_e g, input logic push, input logic [31:0] edata,
                      input string tag);
    logic exp_is, exp_ds, exp_en, exp_we;
    @(posedge clk);
    if (prev_rst) exp_wait = 16'd0;
    else if (prev_stall && exp_wait != 16'hFFFF) exp_wait = exp_wait + 16'd1;
    #1;
    rst          = r;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dwe;
    bus.dm_wsize = dsz;
    bus.dm_addr  = da;
    bus.dm_wdata = dwd;
    #5;
    exp_is = ir & (g != G_IF);
    exp_ds = dr & !(g inside {G_DM, G_DMS, G_ERR});
    exp_en = g inside {G_IF, G_DM, G_DMS};
    exp_we = (g == G_DMS);
    check({tag, ".if_stall"}, {31'd0, bus.if_stall}, {31'd0, exp_is});
    check({tag, ".dm_stall"}, {31'd0, bus.dm_stall}, {31'd0, exp_ds});
    check({tag, ".mem_en"}, {31'd0, bus.mem_en}, {31'd0, exp_en});
    check({tag, ".mem_we"}, {31'd0, bus.mem_we}, {31'd0, exp_we});
    check({tag, ".if_wait_cnt"}, {16'd0, bus.if_wait_cnt}, {16'd0, exp_wait});
    if (exp_en) check({tag, ".mem_addr"}, {22'd0, bus.mem_addr}, {22'd0, (g == G_IF) ? ia : da});
    if (exp_we) begin
      check({tag, ".mem_wdata"}, bus.mem_wdata, dwd);
      check({tag, ".mem_wsize"}, {30'd0, bus.mem_wsize}, {30'd0, dsz});
    end else begin
      check({tag, ".mem_wdata_zero"}, bus.mem_wdata, 32'd0);
    end
    if (push) begin
      case (g)
        G_IF:    sb.push_back('{K_IF, edata});
        G_DM:    sb.push_back('{K_DM_LD, edata});
        G_DMS:   sb.push_back('{K_DM_ST, 32'd0});
        default: sb.push_back('{K_ERR, 32'd0});
      endcase
    end
    prev_stall = exp_is;
    prev_rst   = r;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    last_if      = 32'd0;
    last_dm      = 32'd0;
    exp_wait     = 16'd0;
    prev_stall   = 1'b0;
    prev_rst     = 1'b1;
    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_wsize = 2'b00;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    preload(10'h010, 32'h8C010004);
    preload(10'h020, 32'h12345678);
    preload(10'h030, 32'hCAFEF00D);

    // Reset: grants forced off, stalls mirror the requests.
    step(1, 0, 10'h000, 0, 0, 2'b00, 10'h000, 0, G_NONE, 0, 0, "rst_idle");
    step(1, 1, 10'h010, 1, 0, 2'b00, 10'h020, 0, G_NONE, 0, 0, "rst_both");
    check("rst.if_rdata", bus.if_rdata, 32'd0);
    check("rst.dm_rdata", bus.dm_rdata, 32'd0);

    // IF alone, then a contended cycle that DM wins.
    step(0, 1, 10'h010, 0, 0, 2'b00, 10'h000, 0, G_IF, 1, 32'h8C010004, "if_only");
    step(0, 0, 10'h000, 0, 0, 2'b00, 10'h000, 0, G_NONE, 0, 0, "idle1");
    step(0, 1, 10'h010, 1, 0, 2'b00, 10'h020, 0, G_DM, 1, 32'h12345678, "both_once");
    step(0, 0, 10'h000, 0, 0, 2'b00, 10'h000, 0, G_NONE, 0, 0, "idle2");

    // Steady contention: DM,DM,DM,IF,DM,DM,DM,IF.
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) step(0, 1, 10'h010, 1, 0, 2'b00, 10'h030, 0, G_IF, 1, 32'h8C010004, "contend_if");
      else            step(0, 1, 10'h010, 1, 0, 2'b00, 10'h030, 0, G_DM, 1, 32'hCAFEF00D, "contend_dm");
    end
    step(0, 0, 10'h000, 0, 0, 2'b00, 10'h000, 0, G_NONE, 0, 0, "idle3");
    check("contend.if_wait_cnt_total", {16'd0, bus.if_wait_cnt}, 32'd7);

    // Store then load-after-store, sized stores, misaligned rejections.
    step(0, 0, 10'h000, 1, 1, 2'b00, 10'h040, 32'hDEADBEEF, G_DMS, 1, 0, "st_word");
    step(0, 0, 10'h000, 1, 0, 2'b00, 10'h040, 0, G_DM, 1, 32'hDEADBEEF, "ld_after_st");
    step(0, 0, 10'h000, 1, 1, 2'b10, 10'h041, 32'h000000AA, G_DMS, 1, 0, "st_byte");
    step(0, 0, 10'h000, 1, 1, 2'b01, 10'h042, 32'h00001234, G_DMS, 1, 0, "st_half");
    step(0, 0, 10'h000, 1, 1, 2'b01, 10'h043, 32'h00005555, G_ERR, 1, 0, "st_half_mis");
    step(0, 0, 10'h000, 1, 0, 2'b00, 10'h042, 0, G_ERR, 1, 0, "ld_word_mis");
    step(0, 1, 10'h010, 1, 0, 2'b11, 10'h041, 0, G_ERR, 1, 0, "ld_rsvd_mis");
    step(0, 0, 10'h000, 1, 0, 2'b01, 10'h042, 0, G_DM, 1, 32'h1234AAEF, "ld_half");
    step(0, 0, 10'h000, 1, 0, 2'b00, 10'h040, 0, G_DM, 1, 32'h1234AAEF, "ld_word");
    step(0, 0, 10'h000, 0, 0, 2'b00, 10'h000, 0, G_NONE, 0, 0, "idle4");

    // Reset in the cycle after a grant discards that response and clears the state.
    step(0, 1, 10'h010, 1, 0, 2'b00, 10'h020, 0, G_DM, 1, 32'h12345678, "pre_rst_a");
    step(0, 1, 10'h010, 1, 0, 2'b00, 10'h020, 0, G_DM, 0, 0, "pre_rst_b");
    step(1, 1, 10'h010, 1, 0, 2'b00, 10'h020, 0, G_NONE, 0, 0, "mid_rst");
    last_if = 32'd0;
    last_dm = 32'd0;
    step(0, 0, 10'h000, 0, 0, 2'b00, 10'h000, 0, G_NONE, 0, 0, "post_rst");
    check("post_rst.if_rdata", bus.if_rdata, 32'd0);
    check("post_rst.dm_rdata", bus.dm_rdata, 32'd0);

    // Starvation counter restarted from zero: three DM wins before IF.
    for (int k = 0; k < 4; k++) begin
      if (k == 3) step(0, 1, 10'h010, 1, 0, 2'b00, 10'h020, 0, G_IF, 1, 32'h8C010004, "rst_contend_if");
      else        step(0, 1, 10'h010, 1, 0, 2'b00, 10'h020, 0, G_DM, 1, 32'h12345678, "rst_contend_dm");
    end
    step(0, 0, 10'h000, 0, 0, 2'b00, 10'h000, 0, G_NONE, 0, 0, "idle5");
    step(0, 0, 10'h000, 0, 0, 2'b00, 10'h000, 0, G_NONE, 0, 0, "idle6");
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
